sha256_w_schedule: RTL

SHA256_W_SCHEDULE -- requirements
Module: sha256_w_schedule

---
 rtl/sha256_w_schedule.sv | 82 ++++++++
 1 files changed

// File: rtl/sha256_w_schedule.sv
// SHA-256 message-schedule generator: a 16-word sliding window yields one W[t] per
// `next` pulse, for rounds 0..63, after `init` loads a 512-bit block.
module sha256_w_schedule (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [511:0] block,
    input  logic         init,
    input  logic         next,
    output logic [31:0]  w,
    output logic [5:0]   round,
    output logic         last,
    output logic         busy
);

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    logic [31:0] win_q [16];
    logic [31:0] win_d [16];
    logic [5:0]  round_q, round_d;
    logic        busy_q, busy_d;
    logic        advance;
    logic [31:0] w_new;

    // init wins over next; round 63 is terminal until the next init
    assign advance = next && !init && (round_q != 6'd63);
    assign w_new   = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];

    always_comb begin
        round_d = round_q;
        busy_d  = busy_q;
        if (init) begin
            round_d = 6'd0;
            busy_d  = 1'b1;
        end else if (advance) begin
            round_d = round_q + 6'd1;
            if (round_q == 6'd62) begin
                busy_d = 1'b0;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_win
            if (gi < 15) begin : g_shift
                assign win_d[gi] = init    ? block[511-32*gi -: 32] :
                                   advance ? win_q[gi+1]            : win_q[gi];
            end else begin : g_head
                assign win_d[gi] = init    ? block[511-32*gi -: 32] :
                                   advance ? w_new                  : win_q[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= 32'd0;
            end
            round_q <= 6'd0;
            busy_q  <= 1'b0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= win_d[i];
            end
            round_q <= round_d;
            busy_q  <= busy_d;
        end
    end

    assign w     = win_q[0];
    assign round = round_q;
    assign last  = (round_q == 6'd63);
    assign busy  = busy_q;

endmodule
